// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer (IF/ID/EX/MEM/WB/HALT) that drives datapath enables and the next PC.
// Latency: 3 cycles IF-to-IF for a branch, 4 for R-type, I-ALU, jal and store, 5 for a load.
// No backpressure: the sequencer advances on every edge, and HALT is left only through rst.
// Ports: clk, rst (async, active-high); ins, zero, PCp4, branch, jTarget (in);
//        PCin, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op, state, halt, retired (out).
module ctrl_seq #(
  parameter logic [31:0] ENTRY = 32'h28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] PCp4,
  input  logic [31:0] branch,
  input  logic [31:0] jTarget,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic        halt,
  output logic [15:0] retired
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  logic [2:0]  state_q, state_d;
  logic [6:0]  opc_q;
  logic [2:0]  f3_q;
  logic [31:0] pc_q;
  logic [15:0] retired_q;
  logic        alusrc_q, m2r_q;
  logic [2:0]  op_q;

  // Decode of the live instruction, only consumed on the ID->EX edge.
  logic [6:0]  opc_live;
  logic        opc_valid;
  logic        alusrc_d, m2r_d;
  logic [2:0]  op_d;
  logic        enter_if, id_to_ex;
  logic [31:0] next_pc;

  // Instruction fields this block never looks at (registers, immediates).
  logic unused_ins;
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  assign opc_live  = ins[6:0];
  assign opc_valid = (opc_live == OPC_R)  || (opc_live == OPC_I)  || (opc_live == OPC_LD) ||
                     (opc_live == OPC_ST) || (opc_live == OPC_BR) || (opc_live == OPC_JAL);

  always_comb begin
    alusrc_d = (opc_live != OPC_R) && (opc_live != OPC_BR);
    m2r_d    = (opc_live == OPC_LD);
    op_d     = OP_ADD;
    if (opc_live == OPC_BR) begin
      op_d = OP_SUB;
    end else if (opc_live == OPC_R) begin
      case (ins[14:12])
        3'b000:  op_d = ins[30] ? OP_SUB : OP_ADD;
        3'b111:  op_d = OP_AND;
        3'b110:  op_d = OP_OR;
        default: op_d = OP_ADD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-state logic. EX and MEM steer on the opcode latched in ID.
  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID:   state_d = opc_valid ? S_EX : S_HALT;
      S_EX: begin
        if ((opc_q == OPC_LD) || (opc_q == OPC_ST)) state_d = S_MEM;
        else if (opc_q == OPC_BR)                   state_d = S_IF;
        else                                        state_d = S_WB;
      end
      S_MEM:  state_d = (opc_q == OPC_LD) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Output logic. Enables are pure decodes of state, so rst clears them at once.
  always_comb begin
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    halt     = 1'b0;
    case (state_q)
      S_MEM: begin
        MemRead  = (opc_q == OPC_LD);
        MemWrite = (opc_q == OPC_ST);
      end
      S_WB:   RegWrite = (opc_q != OPC_ST) && (opc_q != OPC_BR);
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign PCin    = pc_q;
  assign retired = retired_q;
  assign ALUSrc  = alusrc_q;
  assign Mem2Reg = m2r_q;
  assign op      = op_q;

  // Retirement happens only when a real instruction completes back into IF.
  assign enter_if = (state_d == S_IF) &&
                    ((state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB));
  assign id_to_ex = (state_q == S_ID) && (state_d == S_EX);

  // zero is sampled live on the EX->IF edge, which is where a branch retires.
  always_comb begin
    next_pc = PCp4;
    if (opc_q == OPC_JAL)                                 next_pc = jTarget;
    else if ((opc_q == OPC_BR) && (f3_q == 3'b000) && zero) next_pc = branch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q     <= 7'h00;
      f3_q      <= 3'b000;
      pc_q      <= ENTRY;
      retired_q <= 16'h0000;
      alusrc_q  <= 1'b0;
      m2r_q     <= 1'b0;
      op_q      <= OP_ADD;
    end else begin
      if (state_q == S_ID) begin
        opc_q <= opc_live;
        f3_q  <= ins[14:12];
      end
      if (id_to_ex) begin
        alusrc_q <= alusrc_d;
        m2r_q    <= m2r_d;
        op_q     <= op_d;
      end else if (enter_if) begin
        alusrc_q <= 1'b0;
        m2r_q    <= 1'b0;
        op_q     <= OP_ADD;
      end
      if (enter_if) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed vector bench for ctrl_seq.
// Latency: each vector runs one instruction from IF to the next IF (or HALT).
// Backpressure: none; the bench follows the sequencer cycle by cycle.
module tb_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] PCp4, branch, jTarget;
  logic [31:0] PCin;
  logic        RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite;
  logic [2:0]  op;
  logic [2:0]  state;
  logic        halt;
  logic [15:0] retired;

  ctrl_seq #(.ENTRY(32'h28)) dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero),
    .PCp4(PCp4), .branch(branch), .jTarget(jTarget),
    .PCin(PCin), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg),
    .MemRead(MemRead), .MemWrite(MemWrite), .op(op), .state(state),
    .halt(halt), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        zero;
    logic [31:0] pcp4;
    logic [31:0] br;
    logic [31:0] jt;
    logic [23:0] seq;    // states seen after each edge, oldest first, F-padded on the left
    logic [2:0]  op;     // sampled in EX
    logic        alusrc; // sampled in EX
    logic        m2r;    // sampled in WB (0 if no WB)
    int          rw;     // cycles with RegWrite=1
    int          mr;
    int          mw;
    logic [31:0] pc;     // PCin after the instruction
  } vec_t;

  int          checks;
  int          errors;
  logic [31:0] exp_pc;
  logic [15:0] exp_ret;
  vec_t        vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Runs one instruction starting in IF. The instruction word is trashed once EX
  // is reached, so later states must work from the copy latched in ID.
  task automatic run_vec(input vec_t v, input string nm);
    logic [23:0] seq;
    int          cyc, rw, mr, mw;
    logic [2:0]  opx;
    logic        asx, m2x;
    logic        hold_ok, done;
    seq = 24'hFFFFFF; cyc = 0; rw = 0; mr = 0; mw = 0;
    opx = 3'b111; asx = 1'b0; m2x = 1'b0; hold_ok = 1'b1; done = 1'b0;
    ins = v.ins; zero = v.zero; PCp4 = v.pcp4; branch = v.br; jTarget = v.jt;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      seq = {seq[19:0], 1'b0, state};
      if (RegWrite) rw++;
      if (MemRead)  mr++;
      if (MemWrite) mw++;
      if (state == 3'd2) begin
        opx = op; asx = ALUSrc;
        ins = 32'hFFFFFFFF;
      end
      if (state == 3'd4) m2x = Mem2Reg;
      if (state == 3'd0 || state == 3'd5 || cyc >= 8) done = 1'b1;
      else if (PCin !== exp_pc) hold_ok = 1'b0;
    end
    if (state == 3'd0) begin
      exp_ret = exp_ret + 16'd1;
      exp_pc  = v.pc;
    end
    chk({nm, "_seq"},    {8'h0, seq},       {8'h0, v.seq});
    chk({nm, "_pc"},     PCin,              v.pc);
    chk({nm, "_op"},     {29'h0, opx},      {29'h0, v.op});
    chk({nm, "_alusrc"}, {31'h0, asx},      {31'h0, v.alusrc});
    chk({nm, "_m2r"},    {31'h0, m2x},      {31'h0, v.m2r});
    chk({nm, "_rw"},     rw,                v.rw);
    chk({nm, "_mr"},     mr,                v.mr);
    chk({nm, "_mw"},     mw,                v.mw);
    chk({nm, "_ret"},    {16'h0, retired},  {16'h0, exp_ret});
    chk({nm, "_pchold"}, {31'h0, hold_ok},  32'h1);
  endtask

  initial begin
    int bad;
    vec_t w;
    checks = 0; errors = 0;
    //        ins           z     pcp4          br            jt            seq         op      as    m2r   rw mr mw pc
    vt[0]  = '{32'h002081B3, 1'b0, 32'h2C, 32'hBAD0, 32'hCAF0, 24'hFF1240, 3'b010, 1'b0, 1'b0, 1, 0, 0, 32'h2C};  // add
    vt[1]  = '{32'h40208133, 1'b1, 32'h30, 32'hBAD0, 32'hCAF0, 24'hFF1240, 3'b110, 1'b0, 1'b0, 1, 0, 0, 32'h30};  // sub
    vt[2]  = '{32'h0020F1B3, 1'b0, 32'h34, 32'hBAD0, 32'hCAF0, 24'hFF1240, 3'b000, 1'b0, 1'b0, 1, 0, 0, 32'h34};  // and
    vt[3]  = '{32'h0020E1B3, 1'b0, 32'h38, 32'hBAD0, 32'hCAF0, 24'hFF1240, 3'b001, 1'b0, 1'b0, 1, 0, 0, 32'h38};  // or
    vt[4]  = '{32'h0020C1B3, 1'b0, 32'h3C, 32'hBAD0, 32'hCAF0, 24'hFF1240, 3'b010, 1'b0, 1'b0, 1, 0, 0, 32'h3C};  // xor
    vt[5]  = '{32'h00108093, 1'b0, 32'h40, 32'hBAD0, 32'hCAF0, 24'hFF1240, 3'b010, 1'b1, 1'b0, 1, 0, 0, 32'h40};  // addi
    vt[6]  = '{32'h0000A103, 1'b0, 32'h44, 32'hBAD0, 32'hCAF0, 24'hF12340, 3'b010, 1'b1, 1'b1, 1, 1, 0, 32'h44};  // lw
    vt[7]  = '{32'h0020A023, 1'b0, 32'h48, 32'hBAD0, 32'hCAF0, 24'hFF1230, 3'b010, 1'b1, 1'b0, 0, 0, 1, 32'h48};  // sw
    vt[8]  = '{32'h00208063, 1'b1, 32'h4C, 32'h40,   32'hCAF0, 24'hFFF120, 3'b110, 1'b0, 1'b0, 0, 0, 0, 32'h40};  // beq taken
    vt[9]  = '{32'h00208063, 1'b0, 32'h44, 32'h80,   32'hCAF0, 24'hFFF120, 3'b110, 1'b0, 1'b0, 0, 0, 0, 32'h44};  // beq not taken
    vt[10] = '{32'h00209063, 1'b1, 32'h48, 32'h90,   32'hCAF0, 24'hFFF120, 3'b110, 1'b0, 1'b0, 0, 0, 0, 32'h48};  // bne, zero=1
    vt[11] = '{32'h008000EF, 1'b0, 32'h4C, 32'hBAD0, 32'h100,  24'hFF1240, 3'b010, 1'b1, 1'b0, 1, 0, 0, 32'h100}; // jal

    rst = 1'b1; ins = 32'h0; zero = 1'b0; PCp4 = 32'h0; branch = 32'h0; jTarget = 32'h0;
    #3;
    chk("rst_state",  {29'h0, state}, 32'h0);
    chk("rst_pc",     PCin, 32'h28);
    chk("rst_op",     {29'h0, op}, 32'h2);
    chk("rst_ctl",    {27'h0, RegWrite, MemRead, MemWrite, ALUSrc, Mem2Reg}, 32'h0);
    chk("rst_halt",   {31'h0, halt}, 32'h0);
    chk("rst_ret",    {16'h0, retired}, 32'h0);
    exp_pc = 32'h28; exp_ret = 16'h0;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Counter wrap: preload FFFF, then one add retires and wraps to 0000.
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    w = vt[0];
    w.pcp4 = exp_pc + 32'h4; w.pc = exp_pc + 32'h4;
    run_vec(w, "wrap");

    // Illegal opcode: HALT after ID, everything frozen.
    ins = 32'hFFFFFFFF; PCp4 = 32'h500; branch = 32'h600; jTarget = 32'h700; zero = 1'b1;
    @(posedge clk); #1;
    chk("halt_id", {29'h0, state}, 32'h1);
    @(posedge clk); #1;
    chk("halt_state", {29'h0, state}, 32'h5);
    chk("halt_flag",  {31'h0, halt}, 32'h1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (PCin !== exp_pc || retired !== exp_ret || state !== 3'd5 ||
          RegWrite || MemRead || MemWrite || halt !== 1'b1) bad++;
    end
    chk("halt_frozen", bad, 0);
    #2 rst = 1'b1;
    #1;
    chk("halt_rst_pc",    PCin, 32'h28);
    chk("halt_rst_state", {29'h0, state}, 32'h0);
    chk("halt_rst_flag",  {31'h0, halt}, 32'h0);
    @(negedge clk); rst = 1'b0;
    exp_pc = 32'h28; exp_ret = 16'h0;

    // Reset in MEM of a store: MemWrite must drop without waiting for a clock.
    ins = 32'h0020A023; PCp4 = 32'h2C; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("st_mem_state", {29'h0, state}, 32'h3);
    chk("st_mem_mw",    {31'h0, MemWrite}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("st_rst_mw",    {31'h0, MemWrite}, 32'h0);
    chk("st_rst_state", {29'h0, state}, 32'h0);
    chk("st_rst_pc",    PCin, 32'h28);
    chk("st_rst_ret",   {16'h0, retired}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_id",  {29'h0, state}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
